// File: rtl/vec_lane_alu_seq.sv
// Multi-cycle vector ALU. The operands are captured when a request is
// accepted. After that the unit computes one S-bit lane per clock, and the
// full vector is available on result while done is high.
//
// Handshake: start is a request with no ready/ack. It is accepted on any
// rising edge where busy=0 and start=1, which covers the IDLE state and the
// DONE cycle. It is ignored while busy=1. done is high for exactly one cycle
// per accepted request. The consumer must capture result during that cycle,
// because a back-to-back request clears result on the next edge.
module vec_lane_alu_seq #(
  parameter int S = 32,
  parameter int V = 192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         use_scalar,
  input  logic [V-1:0] vec_a,
  input  logic [V-1:0] vec_b,
  input  logic [S-1:0] scal,
  output logic         busy,
  output logic         done,
  output logic [V-1:0] result
);

  localparam int LANES = V / S;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SHW   = $clog2(S);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_SLL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [V-1:0]  r_a;
  logic [V-1:0]  r_b;
  logic [S-1:0]  r_res [LANES];
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic [V-1:0]  w_b_in;
  logic [S-1:0]  w_a_lane [LANES];
  logic [S-1:0]  w_b_lane [LANES];
  logic [S-1:0]  w_a_sel;
  logic [S-1:0]  w_b_sel;
  logic [S-1:0]  w_lane_res;

  // A request is taken whenever the unit is not computing.
  assign w_accept = start && (r_state != RUN);

  // Resolve the broadcast at accept time so the lane datapath only ever sees
  // a vector operand B.
  assign w_b_in = use_scalar ? {LANES{scal}} : vec_b;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_a_lane[g]        = r_a[g*S +: S];
    assign w_b_lane[g]        = r_b[g*S +: S];
    assign result[g*S +: S]   = r_res[g];
  end

  assign w_a_sel = w_a_lane[r_cnt];
  assign w_b_sel = w_b_lane[r_cnt];

  // Single lane ALU: unsigned and modulo 2^S. MUL keeps the low half of the
  // product, and SLL uses only the low log2(S) bits of B.
  always_comb begin
    w_lane_res = '0;
    case (r_op)
      OP_ADD:  w_lane_res = w_a_sel + w_b_sel;
      OP_SUB:  w_lane_res = w_a_sel - w_b_sel;
      OP_MUL:  w_lane_res = w_a_sel * w_b_sel;
      OP_SLL:  w_lane_res = w_a_sel << w_b_sel[SHW-1:0];
      default: w_lane_res = '0;
    endcase
  end

  // Next-state logic: IDLE/DONE -> RUN on accept; RUN walks every lane,
  // then spends exactly one cycle in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = (r_cnt == LAST_LANE) ? DONE : RUN;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register. busy and done are flops loaded from the next state, so
  // they have no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Operand capture. The inputs are free to change after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= vec_a;
      r_b  <= w_b_in;
    end
  end

  // Lane counter: cleared on accept, advanced once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == RUN && r_cnt != LAST_LANE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result lanes: cleared on accept. Each RUN cycle writes only the current
  // lane, and the value is held in IDLE until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) r_res[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) r_res[i] <= '0;
    end else if (r_state == RUN) begin
      r_res[r_cnt] <= w_lane_res;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_vec_lane_alu_seq.sv
// Directed bench for vec_lane_alu_seq. Expected vectors come from a per-lane
// reference model. They are queued at launch and popped when done is sampled.
module tb_vec_lane_alu_seq;

  localparam int S = 32;
  localparam int V = 192;
  localparam int LANES = V / S;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         use_scalar;
  logic [V-1:0] vec_a;
  logic [V-1:0] vec_b;
  logic [S-1:0] scal;
  logic         busy;
  logic         done;
  logic [V-1:0] result;

  logic [V-1:0] exp_q[$];
  logic [V-1:0] cur_exp;
  logic [V-1:0] last_exp;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;

  vec_lane_alu_seq #(.S(S), .V(V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .use_scalar (use_scalar),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .scal       (scal),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [V-1:0] model(input logic [1:0] f_op,
                                         input logic [V-1:0] a,
                                         input logic [V-1:0] b,
                                         input logic us,
                                         input logic [S-1:0] sc);
    logic [V-1:0] r;
    logic [S-1:0] la, lb;
    logic [2*S-1:0] prod;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*S +: S];
      lb = us ? sc : b[i*S +: S];
      prod = {{S{1'b0}}, la} * {{S{1'b0}}, lb};
      case (f_op)
        2'b00: r[i*S +: S] = la + lb;
        2'b01: r[i*S +: S] = la - lb;
        2'b10: r[i*S +: S] = prod[S-1:0];
        default: r[i*S +: S] = la << lb[4:0];
      endcase
    end
    return r;
  endfunction

  // Lanes below n taken from the full expected vector; the rest are still zero.
  function automatic logic [V-1:0] partial(input logic [V-1:0] full, input int n);
    logic [V-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (i < n) r[i*S +: S] = full[i*S +: S];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n, input logic [V-1:0] exp_res);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_busy", V'(busy), '0);
      chk("idle_done", V'(done), '0);
      chk("idle_result", result, exp_res);
    end
  endtask

  // Drive a request, let the accept edge pass, and check that result was cleared.
  task automatic launch(input logic [1:0] l_op, input logic [V-1:0] a,
                        input logic [V-1:0] b, input logic us, input logic [S-1:0] sc,
                        input logic keep_start);
    op = l_op; vec_a = a; vec_b = b; use_scalar = us; scal = sc;
    start = 1'b1;
    cur_exp = model(l_op, a, b, us, sc);
    exp_q.push_back(cur_exp);
    step();
    if (!keep_start) start = 1'b0;
    chk("accept_busy", V'(busy), V'(1));
    chk("accept_done", V'(done), '0);
    chk("accept_cleared", result, '0);
  endtask

  // Six lane edges. The inputs are scrambled to show the captured operands are used.
  task automatic run_lanes(input logic keep_start);
    logic [V-1:0] got;
    for (int i = 0; i < LANES; i++) begin
      vec_a = {6{$urandom()}};
      vec_b = {6{$urandom()}};
      scal  = $urandom();
      op    = 2'($urandom_range(0, 3));
      use_scalar = 1'($urandom_range(0, 1));
      step();
      if (i < LANES - 1) begin
        chk("run_busy", V'(busy), V'(1));
        chk("run_done", V'(done), '0);
        chk("run_partial", result, partial(cur_exp, i + 1));
      end
    end
    start = 1'b0;
    chk("done_pulse", V'(done), V'(1));
    chk("done_busy", V'(busy), '0);
    if (exp_q.size() == 0) begin
      chk("queue_empty", V'(1), '0);
    end else begin
      got = exp_q.pop_front();
      chk("done_result", result, got);
      last_exp = got;
    end
  endtask

  initial begin
    logic [V-1:0] a, b;

    // Reset, then idle with no start
    rst_n = 1'b0; start = 1'b0; op = '0; use_scalar = 1'b0;
    vec_a = '0; vec_b = '0; scal = '0;
    repeat (3) step();
    chk("reset_busy", V'(busy), '0);
    chk("reset_done", V'(done), '0);
    chk("reset_result", result, '0);
    rst_n = 1'b1;
    idle_check(10, '0);

    // ADD vector: A lanes 1..6, B lanes 10..60
    for (int i = 0; i < LANES; i++) begin
      a[i*S +: S] = S'(i + 1);
      b[i*S +: S] = S'(10 * (i + 1));
    end
    launch(2'b00, a, b, 1'b0, '0, 1'b0);
    chk("add_model", cur_exp, {32'd66, 32'd55, 32'd44, 32'd33, 32'd22, 32'd11});
    run_lanes(1'b0);
    idle_check(3, last_exp);

    // Scalar SUB wraps to all ones
    launch(2'b01, '0, {6{32'h1234_5678}}, 1'b1, 32'd1, 1'b0);
    run_lanes(1'b0);
    chk("sub_wrap", last_exp, {6{32'hFFFF_FFFF}});
    idle_check(1, last_exp);

    // Scalar SLL uses only B[4:0]
    launch(2'b11, {6{32'h8000_0001}}, '0, 1'b1, 32'h21, 1'b0);
    run_lanes(1'b0);
    chk("sll_mod", last_exp, {6{32'h0000_0002}});

    // MUL truncation, with lane 3 using B=3
    b = {6{32'h0001_0000}};
    b[3*S +: S] = 32'h3;
    launch(2'b10, {6{32'h0001_0000}}, b, 1'b0, '0, 1'b0);
    run_lanes(1'b0);
    chk("mul_trunc", last_exp, {32'h0, 32'h0, 32'h0003_0000, 32'h0, 32'h0, 32'h0});

    // start held high for the whole RUN: no restart mid-vector
    idle_check(1, last_exp);
    launch(2'b00, {6{32'd7}}, {6{32'd5}}, 1'b0, '0, 1'b1);
    run_lanes(1'b1);
    idle_check(2, last_exp);

    // start in the DONE cycle: accepted with no bubble
    launch(2'b00, {6{32'd100}}, {6{32'd1}}, 1'b0, '0, 1'b0);
    run_lanes(1'b0);
    launch(2'b01, {6{32'd100}}, '0, 1'b1, 32'd30, 1'b0);
    run_lanes(1'b0);
    chk("b2b_second", last_exp, {6{32'd70}});
    idle_check(2, last_exp);

    // Asynchronous reset mid-operation, after lane 2 has been written
    launch(2'b00, {6{32'd2}}, {6{32'd3}}, 1'b0, '0, 1'b0);
    repeat (3) step();
    chk("pre_rst_partial", result, partial(cur_exp, 3));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", V'(busy), '0);
    chk("async_rst_done", V'(done), '0);
    chk("async_rst_result", result, '0);
    exp_q.delete();
    step();
    #2 rst_n = 1'b1;
    idle_check(10, '0);

    chk("queue_drained", V'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_lane_alu_seq.md
Name: vec_lane_alu_seq

Overview:
- Multi-cycle vector ALU in the execute stage, directly upstream of the writeback select mux.
- Processes one 32-bit lane per cycle over a 192-bit vector (6 lanes).
- Presents the full vector result on `result`, which drives the mux's vector input.
- Second operand is either a vector or a broadcast scalar.

Parameters:
- S, 32, lane/scalar width in bits
- V, 192, vector width in bits; must be an integer multiple of S
- LANES, V/S (6), number of lanes; derived, not overridden

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00 ADD, 01 SUB, 10 MUL (low S bits), 11 SLL
- use_scalar  input  1  1: operand B of every lane = scal; 0: operand B = vec_b lane
- vec_a  input  V  vector operand A; lane i = bits [S*i+S-1 : S*i]
- vec_b  input  V  vector operand B
- scal  input  S  scalar operand B, broadcast to all lanes
- busy  output  1  high while lanes are being computed
- done  output  1  one-cycle pulse when result is complete
- result  output  V  vector result register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, lane counter=0, busy=0, done=0, result=0, operand registers=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE: start=1 at edge -> RUN.
  - RUN, counter<LANES-1 -> RUN; counter==LANES-1 -> DONE.
  - DONE: start=1 -> RUN; else -> IDLE.
- Accept (IDLE or DONE with start=1), at the same edge:
  - latch vec_a, op, use_scalar, and operand B (vec_b or scal) into internal registers;
  - clear counter to 0 and result to 0.
  - Inputs may change after the accept edge without effect.
- RUN: each edge writes result lane[counter] = f(A lane, B lane) and increments counter. All other lanes are held.
- Latency: start accepted at edge k -> lanes 0..5 written at edges k+1..k+6 -> done=1 in the cycle after edge k+6. Exactly one cycle, exactly once per accepted start.
- busy = 1 iff state==RUN. done = 1 iff state==DONE. Both are registered outputs with no combinational path from inputs.
- start while busy=1 is ignored; there is no queueing.
- start during the DONE cycle is accepted: no idle bubble, done still pulses for that cycle, and result is cleared at that edge. The downstream stage must capture result on done.
- result holds its value in IDLE indefinitely after DONE.
- Arithmetic (unsigned, all S-bit):
  - ADD: (A+B) mod 2^S.
  - SUB: (A−B) mod 2^S.
  - MUL: low S bits of the 2S-bit product.
  - SLL: A << B[4:0]; upper bits of B ignored; zero fill.
- No overflow/carry flags.
- op value latched at accept governs all 6 lanes; there are no mixed ops within one vector.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start for 10 cycles -> busy=0, done=0, result=0 throughout.
- ADD vector: vec_a lanes 0..5 = 1..6, vec_b lanes = 10..60 step 10, op=00, use_scalar=0, start 1 cycle at edge k.
  - busy high for edges k+1..k+6;
  - lane i becomes non-zero at edge k+1+i;
  - done single pulse after k+6;
  - result lanes = 11,22,33,44,55,66.
- Scalar SUB/SLL wrap:
  - op=01, vec_a all lanes=0, scal=1, use_scalar=1 -> every lane 0xFFFFFFFF.
  - then op=11, vec_a lanes=0x80000001, scal=0x21 -> shift 1 -> every lane 0x00000002.
- MUL truncation: vec_a lanes=0x00010000, vec_b lanes=0x00010000, op=10 -> every lane 0x00000000. Lane 3 with vec_b=0x00000003 -> lane 3 = 0x00030000.
- Start handling:
  - start held high continuously during RUN -> ignored; no restart mid-vector.
  - start=1 in the DONE cycle with new operands -> done pulses once, result cleared at that edge, busy=1 next cycle, second result correct after 6 more edges.
- Mid-operation reset: assert rst_n low asynchronously between clock edges after lane 2 is written -> busy, done, result go to 0 immediately. After release with no start, the FSM stays IDLE and done never pulses.
